// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command initiator: bus widths, FSM encoding and
// harness register addresses.
package wb_cmd_master_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    localparam logic [WB_ADR_W-1:0] HARNESS_ACTIVE_ADR = 32'h3000_0000;
    localparam logic [WB_ADR_W-1:0] HARNESS_OEB0_ADR   = 32'h3000_0004;
    localparam logic [WB_ADR_W-1:0] HARNESS_OEB1_ADR   = 32'h3000_0008;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGap  = 2'd1,
        StBus  = 2'd2,
        StResp = 2'd3
    } state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready command port.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i
);

    state_e state_q, state_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;

    logic ack_hit;
    logic timeout_hit;

    // Ack is only meaningful while a cycle is on the bus.
    assign ack_hit = (state_q == StBus) && wbm_ack_i;

`ifdef WB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counter sits at zero outside BUS, so it is already clear on entry.
    assign to_cnt_d    = (state_q == StBus) ? to_cnt_q + TO_W'(1) : '0;
    assign timeout_hit = (state_q == StBus) && !wbm_ack_i &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^{TIMEOUT_CYCLES, TO_W};
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid_i)                state_d = StBus;
            StBus:  if (ack_hit || timeout_hit)     state_d = StResp;
            StResp: if (rsp_ready_i)                state_d = StGap;
            StGap:                                  state_d = StIdle;
            default:                                state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    cyc_d = 1'b1;
                    we_d  = cmd_we_i;
                    adr_d = cmd_adr_i;
                    sel_d = cmd_we_i ? cmd_sel_i : {WB_SEL_W{1'b1}};
                    dat_d = cmd_we_i ? cmd_dat_i : '0;
                end
            end
            StBus: begin
                if (ack_hit || timeout_hit) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !ack_hit;
                    rsp_dat_d   = (ack_hit && !we_q) ? wbm_dat_i : '0;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a Wishbone slave model of programmable ack delay.
// Build with WB_TIMEOUT_EN defined to exercise the timeout path.
module tb_wb_cmd_master;
    import wb_cmd_master_pkg::*;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        ack_r = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Slave model: registered ack after ack_delay cycles of cyc; optional stale extra ack cycle.
    int unsigned ack_delay = 1;
    bit          never_ack = 1'b0;
    bit          stale     = 1'b0;
    logic        stale_held = 1'b0;
    int unsigned s_cnt = 0;
    logic [31:0] sregs [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    assign wbm_dat_i = sregs[wbm_adr_o[3:2]];

    always @(posedge clk) begin
        if (ack_r) begin
            if (stale && !stale_held) begin
                stale_held <= 1'b1;
            end else begin
                ack_r      <= 1'b0;
                stale_held <= 1'b0;
            end
        end else if (wbm_cyc_o && wbm_stb_o && !never_ack) begin
            if (s_cnt + 1 >= ack_delay) begin
                ack_r <= 1'b1;
                s_cnt <= 0;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_cnt <= 0;
        end
        if (wbm_cyc_o && wbm_stb_o && wbm_we_o && ack_r) begin
            for (int b = 0; b < 4; b++) begin
                if (wbm_sel_o[b]) sregs[wbm_adr_o[3:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
            end
        end
    end

    // Bus monitor, sampled just after each rising edge.
    int          pulses = 0, hi_len = 0, last_hi = 0, lo_len = 0, min_gap = 1000;
    int          stb_bad = 0, rsp_rises = 0;
    logic        cyc_prev = 1'b0, rv_prev = 1'b0, seen_we = 1'b0;
    logic [3:0]  seen_sel = '0;
    logic [31:0] seen_dat = '0, last_rsp_dat = '0;

    always @(posedge clk) begin
        #1;
        if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
        if (wbm_cyc_o) begin
            if (!cyc_prev) begin
                pulses++;
                if (lo_len < min_gap) min_gap = lo_len;
                hi_len = 0;
            end
            hi_len++;
            seen_we  = wbm_we_o;
            seen_sel = wbm_sel_o;
            seen_dat = wbm_dat_o;
        end else begin
            if (cyc_prev) begin
                last_hi = hi_len;
                lo_len  = 0;
            end
            lo_len++;
        end
        cyc_prev = wbm_cyc_o;
        if (rsp_valid_o && !rv_prev) begin
            rsp_rises++;
            last_rsp_dat = rsp_dat_o;
        end
        rv_prev = rsp_valid_o;
    end

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output bit ok);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready_o) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (rsp_valid_o) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int unsigned delay;
        logic [31:0] exp_rdat;
        logic [3:0]  exp_sel;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int p0;
        p0 = pulses;
        ack_delay = v.delay;
        issue(v.we, v.adr, v.dat, v.sel, ok);
        check($sformatf("v%0d accept", idx), 32'(ok), 32'd1);
        wait_rsp(50, ok);
        check($sformatf("v%0d rsp_valid", idx), 32'(ok), 32'd1);
        check($sformatf("v%0d rsp_dat", idx), rsp_dat_o, v.exp_rdat);
        check($sformatf("v%0d rsp_err", idx), 32'(rsp_err_o), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d cyc pulses", idx), 32'(pulses - p0), 32'd1);
        check($sformatf("v%0d cyc length", idx), 32'(last_hi), v.delay + 1);
        check($sformatf("v%0d wb we", idx), 32'(seen_we), 32'(v.we));
        check($sformatf("v%0d wb sel", idx), 32'(seen_sel), 32'(v.exp_sel));
        check($sformatf("v%0d wb dat_o", idx), seen_dat, v.we ? v.dat : 32'h0);
        if (v.we) check($sformatf("v%0d slave reg", idx), sregs[v.adr[3:2]], v.exp_reg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          p0, r0, bad, hi_cnt, saw;
        logic [31:0] d0;

        vecs[0] = '{1'b1, HARNESS_ACTIVE_ADR, 32'h0000_0003, 4'hF, 1, 32'h0, 4'hF, 32'h0000_0003};
        vecs[1] = '{1'b0, HARNESS_ACTIVE_ADR, 32'hDEAD_BEEF, 4'h0, 1, 32'h3, 4'hF, 32'h0};
        vecs[2] = '{1'b1, HARNESS_OEB0_ADR, 32'hA5A5_1234, 4'h3, 2, 32'h0, 4'h3, 32'h0000_1234};
        vecs[3] = '{1'b0, HARNESS_OEB0_ADR, 32'h0, 4'hF, 2, 32'h0000_1234, 4'hF, 32'h0};
        vecs[4] = '{1'b1, HARNESS_OEB1_ADR, 32'hFFFF_FFFF, 4'hC, 3, 32'h0, 4'hC, 32'hFFFF_0000};
        vecs[5] = '{1'b0, HARNESS_OEB1_ADR, 32'h1111_1111, 4'h1, 3, 32'hFFFF_0000, 4'hF, 32'h0};

        #1 rstn = 1'b0;
        #1;
        check("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("reset cyc/stb/we", {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
        check("reset rsp_valid/err", {30'h0, rsp_valid_o, rsp_err_o}, 32'h0);
        check("reset rsp_dat", rsp_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Writes and reads to the harness registers, including byte-lane writes.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Response back-pressure: outputs hold, no new bus activity, then GAP before IDLE.
        ack_delay = 1;
        p0 = pulses;
        issue(1'b0, HARNESS_ACTIVE_ADR, 32'h0, 4'hF, ok);
        wait_rsp(50, ok);
        check("hold rsp_valid", 32'(ok), 32'd1);
        d0 = rsp_dat_o;
        check("hold rsp_dat", d0, 32'h3);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_dat_o !== d0 || cmd_ready_o || wbm_cyc_o) bad++;
        end
        check("hold stable", 32'(bad), 32'd0);
        check("hold one pulse", 32'(pulses - p0), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("gap rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("gap cmd_ready", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        check("idle cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Back-to-back commands against a slave whose ack lingers one cycle.
        min_gap = 1000;
        p0 = pulses;
        r0 = rsp_rises;
        ack_delay = 2;
        stale = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b1, HARNESS_OEB0_ADR, 32'h0000_0011, 4'hF, ok);
        cmd_we = 1'b0; cmd_adr = HARNESS_OEB0_ADR; cmd_dat = '0; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready_o) ok = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b second accept", 32'(ok), 32'd1);
        for (int i = 0; i < 50 && (rsp_rises - r0) < 2; i++) @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        stale = 1'b0;
        check("b2b responses", 32'(rsp_rises - r0), 32'd2);
        check("b2b pulses", 32'(pulses - p0), 32'd2);
        check("b2b min low gap>=2", 32'(min_gap >= 2), 32'd1);
        check("b2b second cyc length", 32'(last_hi), 32'd3);
        check("b2b read data", last_rsp_dat, 32'h0000_0011);

        // Slave that never acks.
        never_ack = 1'b1;
`ifdef WB_TIMEOUT_EN
        issue(1'b0, HARNESS_OEB1_ADR, 32'h0, 4'hF, ok);
        wait_rsp(40, ok);
        check("timeout rsp_valid", 32'(ok), 32'd1);
        check("timeout rsp_err", 32'(rsp_err_o), 32'd1);
        check("timeout rsp_dat", rsp_dat_o, 32'h0);
        check("timeout cyc length", 32'(last_hi), 32'd8);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, HARNESS_OEB1_ADR, 32'h0, 4'hF, ok);
        repeat (2) @(negedge clk);
`else
        issue(1'b0, HARNESS_OEB1_ADR, 32'h0, 4'hF, ok);
        hi_cnt = 0;
        saw = 0;
        repeat (1000) begin
            @(negedge clk);
            if (wbm_cyc_o) hi_cnt++;
            if (rsp_valid_o) saw++;
        end
        check("no-timeout cyc held", 32'(hi_cnt), 32'd1000);
        check("no-timeout no response", 32'(saw), 32'd0);
`endif

        // Asynchronous reset in the middle of a bus cycle.
        check("mid-bus cyc before reset", 32'(wbm_cyc_o), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async reset cyc/stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        check("async reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("async reset cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        never_ack = 1'b0;
        @(negedge clk);
        check("post reset cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("post reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        run_vec(vecs[1], 6);

        check("stb tracks cyc", 32'(stb_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
